regfile_sequencer: RTL and testbench

Command-driven controller that owns the write and read ports of the 8 x 16-bit register file. It accepts one register-to-register operation per handshake and fetches operands through the register file's combinational read port. It computes the result in a small ALU and writes it back through the load-enabled write port. It sits between the instruction front end and the register file, driving `writenum`/`readnum`/`write`/`data_in` and consuming `data_out`.

---
 rtl/regfile_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//
// Command-driven controller that owns the ports of an 8 x WIDTH register
// file. One register-to-register command is accepted per handshake
// (start while ready). Operands are fetched through the register file's
// combinational read port, combined in a small ALU and written back
// through the load-enabled write port.
//
// Optional feature macro: REGSEQ_STATUS_EN
//   defined   -> status holds {V,N,Z} of the last ALU result
//   undefined -> status is tied to 3'b000 and no flag flops are built
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous active-high reset, forces IDLE
//   start     in   command valid, taken only while ready=1
//   ready     out  high in IDLE only
//   op        in   00 MOVI, 01 ADD, 10 AND, 11 MVN
//   rd/rn/rm  in   destination / source register numbers
//   imm       in   immediate for MOVI
//   writenum  out  register file write select
//   write     out  register file write enable
//   data_in   out  register file write data
//   readnum   out  register file read select
//   data_out  in   register file read data (combinational on readnum)
//   done      out  one-cycle pulse, coincident with write
//   status    out  {V,N,Z} of the last ALU result
module regfile_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [2:0]       rd,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [WIDTH-1:0] imm,
  output logic [2:0]       writenum,
  output logic             write,
  output logic [WIDTH-1:0] data_in,
  output logic [2:0]       readnum,
  input  logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic [2:0]       status
);

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t           state_reg;
  logic             ready_reg;
  logic             write_reg;
  logic [2:0]       writenum_reg;
  logic [2:0]       readnum_reg;
  logic [1:0]       op_reg;
  logic [2:0]       rd_reg;
  logic [2:0]       rm_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;

  logic [WIDTH-1:0] alu_sum;
  logic [WIDTH-1:0] alu_result;

  // ALU works only on latched operands, so the result never depends on
  // the live command inputs.
  always_comb begin
    alu_sum    = a_reg + b_reg;  // carry out intentionally dropped
    alu_result = b_reg;
    case (op_reg)
      OP_ADD:  alu_result = alu_sum;
      OP_AND:  alu_result = a_reg & b_reg;
      OP_MVN:  alu_result = ~b_reg;
      default: alu_result = b_reg;  // MOVI never reaches EXEC
    endcase
  end

  // Control FSM. Every output is a flop; readnum/writenum are loaded on
  // the edge that enters the state using them so the register file sees
  // the right select for the whole cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      ready_reg    <= 1'b1;
      write_reg    <= 1'b0;
      writenum_reg <= '0;
      readnum_reg  <= '0;
      op_reg       <= OP_MOVI;
      rd_reg       <= '0;
      rm_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg    <= op;
            rd_reg    <= rd;
            rm_reg    <= rm;
            ready_reg <= 1'b0;
            case (op)
              OP_MOVI: begin
                c_reg        <= imm;
                writenum_reg <= rd;
                write_reg    <= 1'b1;
                state_reg    <= S_WRITE;
              end
              OP_MVN: begin
                // A is unused, skip straight to the rm fetch
                readnum_reg <= rm;
                state_reg   <= S_READ_B;
              end
              default: begin
                readnum_reg <= rn;
                state_reg   <= S_READ_A;
              end
            endcase
          end
        end
        S_READ_A: begin
          a_reg       <= data_out;
          readnum_reg <= rm_reg;
          state_reg   <= S_READ_B;
        end
        S_READ_B: begin
          b_reg     <= data_out;
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          c_reg        <= alu_result;
          writenum_reg <= rd_reg;
          write_reg    <= 1'b1;
          state_reg    <= S_WRITE;
        end
        S_WRITE: begin
          write_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          write_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REGSEQ_STATUS_EN
  logic       alu_v;
  logic [2:0] status_reg;

  // Signed overflow: operands share a sign and the sum's sign differs.
  always_comb begin
    alu_v = (op_reg == OP_ADD) &&
            (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
            (alu_sum[WIDTH-1] != a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_reg <= '0;
    end else if (state_reg == S_EXEC) begin
      status_reg <= {alu_v, alu_result[WIDTH-1], (alu_result == '0)};
    end
  end

  assign status = status_reg;
`else
  assign status = 3'b000;
`endif

  assign ready    = ready_reg;
  assign write    = write_reg;
  assign done     = write_reg;
  assign writenum = writenum_reg;
  assign readnum  = readnum_reg;
  assign data_in  = c_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer: register file model driven by the DUT,
// directed table of commands, hand-written ignore/reset sequences and
// randomized commands checked against a behavioural reference.
module tb_regfile_sequencer;

  localparam int W = 16;
  localparam logic [1:0] MOVI = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] ANDO = 2'b10;
  localparam logic [1:0] MVN  = 2'b11;

`ifdef REGSEQ_STATUS_EN
  localparam bit STATUS_ON = 1'b1;
`else
  localparam bit STATUS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         ready;
  logic [1:0]   op;
  logic [2:0]   rd, rn, rm;
  logic [W-1:0] imm;
  logic [2:0]   writenum;
  logic         write;
  logic [W-1:0] data_in;
  logic [2:0]   readnum;
  logic [W-1:0] data_out;
  logic         done;
  logic [2:0]   status;

  always #5 clk = ~clk;

  regfile_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .op(op),
    .rd(rd), .rn(rn), .rm(rm), .imm(imm), .writenum(writenum),
    .write(write), .data_in(data_in), .readnum(readnum),
    .data_out(data_out), .done(done), .status(status)
  );

  // Register file attached to the DUT
  logic [W-1:0] rf [8];
  assign data_out = rf[readnum];
  always @(posedge clk) if (write) rf[writenum] <= data_in;

  int wr_count = 0;
  always @(posedge clk) if (write) wr_count <= wr_count + 1;

  // Reference state
  logic [W-1:0] ref_rf [8];
  logic [2:0]   ref_status;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural result/flags from plain integer arithmetic
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] im, output logic [W-1:0] res,
                       output logic [2:0] fl, output bit upd);
    int ua, ub, sa, sb, ss, r;
    bit v;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    v = 1'b0;
    upd = 1'b1;
    case (o)
      MOVI: begin r = int'(im); upd = 1'b0; end
      ADD: begin
        r = (ua + ub) % 65536;
        ss = sa + sb;
        v = (ss > 32767) || (ss < -32768);
      end
      ANDO: r = ua & ub;
      default: r = 65535 - ub;
    endcase
    res = r[W-1:0];
    fl = {v, (r >= 32768), (r == 0)};
  endtask

  // Issue one command; entered and left at a negedge with ready expected high.
  task automatic run_cmd(input logic [1:0] o, input logic [2:0] d, input logic [2:0] n,
                         input logic [2:0] m, input logic [W-1:0] im, input bit inject);
    logic [W-1:0] res;
    logic [2:0]   fl;
    bit           upd;
    int           lat, cyc;
    logic [2:0]   inj_rd;
    inj_rd = d + 3'd1;
    model(o, ref_rf[n], ref_rf[m], im, res, fl, upd);
    lat = (o == MOVI) ? 1 : (o == MVN) ? 3 : 4;
    check("ready_idle", ready, 1);
    start = 1'b1; op = o; rd = d; rn = n; rm = m; imm = im;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom);
    imm = 16'($urandom);
    if (upd && STATUS_ON) ref_status = fl;
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (inject && cyc == 3) start = 1'b0;
      if (cyc == 1) check("ready_busy", ready, 0);
      if ((o == ADD || o == ANDO) && cyc == 1) check("readnum_rn", readnum, n);
      if ((o == ADD || o == ANDO) && cyc == 2) check("readnum_rm", readnum, m);
      if (o == MVN && cyc == 1) check("readnum_rm", readnum, m);
      if (write) break;
      if (inject && cyc == 2) begin
        start = 1'b1; op = MOVI; rd = inj_rd; imm = ~ref_rf[inj_rd];
      end
    end
    check("write_latency", cyc, lat);
    check("writenum", writenum, d);
    check("data_in", data_in, res);
    check("done", done, 1);
    check("status", status, ref_status);
    @(negedge clk);
    ref_rf[d] = res;
    check("post_write", {ready, write, done}, 3'b100);
    check("rf_dest", rf[d], ref_rf[d]);
    if (inject) check("ignored_start_reg", rf[inj_rd], ref_rf[inj_rd]);
    $display("cmd op=%0d rd=%0d rn=%0d rm=%0d imm=%h -> data=%h status=%b lat=%0d",
             o, d, n, m, im, res, ref_status, cyc);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [2:0]   rd, rn, rm;
    logic [W-1:0] imm;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_status;
    bit           chk_status;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    vecs[0]  = '{MOVI, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 3'b000, 1'b0};
    vecs[1]  = '{MOVI, 3'd2, 3'd0, 3'd0, 16'h0007, 16'h0007, 3'b000, 1'b0};
    vecs[2]  = '{MOVI, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 3'b000, 1'b0};
    vecs[3]  = '{ADD,  3'd4, 3'd1, 3'd2, 16'h0000, 16'h000C, 3'b000, 1'b1};
    vecs[4]  = '{MOVI, 3'd0, 3'd0, 3'd0, 16'h00FF, 16'h00FF, 3'b000, 1'b0};
    vecs[5]  = '{MVN,  3'd0, 3'd0, 3'd0, 16'h0000, 16'hFF00, 3'b010, 1'b1};
    vecs[6]  = '{MOVI, 3'd5, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 3'b000, 1'b0};
    vecs[7]  = '{MOVI, 3'd6, 3'd0, 3'd0, 16'h0001, 16'h0001, 3'b000, 1'b0};
    vecs[8]  = '{ADD,  3'd7, 3'd5, 3'd6, 16'h0000, 16'h8000, 3'b110, 1'b1};
    vecs[9]  = '{MOVI, 3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b000, 1'b0};
    vecs[10] = '{ANDO, 3'd3, 3'd5, 3'd1, 16'h0000, 16'h0000, 3'b001, 1'b1};

    reset = 1'b1; start = 1'b0; op = '0; rd = '0; rn = '0; rm = '0; imm = '0;
    ref_status = 3'b000;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_write_done", {write, done}, 2'b00);
    check("rst_writenum", writenum, 0);
    check("rst_readnum", readnum, 0);
    check("rst_data_in", data_in, 0);
    check("rst_status", status, 0);
    reset = 1'b0;
    @(negedge clk);

    // Preload every register so the model and file agree
    for (int i = 0; i < 8; i++) run_cmd(MOVI, 3'(i), 3'd0, 3'd0, 16'($urandom), 1'b0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, 1'b0);
      check("tbl_data", rf[vecs[i].rd], vecs[i].exp_data);
      if (vecs[i].chk_status)
        check("tbl_status", status, STATUS_ON ? vecs[i].exp_status : 3'b000);
    end

    // MOVI rd=2 pulsed during READ_B of an ADD must be ignored
    run_cmd(ADD, 3'd1, 3'd1, 3'd2, 16'h0000, 1'b1);

    // Reset during EXEC: no write, ready/status cleared at once, dest kept
    run_cmd(MOVI, 3'd6, 3'd0, 3'd0, 16'h0003, 1'b0);
    run_cmd(ADD,  3'd5, 3'd6, 3'd6, 16'h0000, 1'b0);
    start = 1'b1; op = ADD; rd = 3'd6; rn = 3'd5; rm = 3'd6;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    wc = wr_count;
    reset = 1'b1;
    #1;
    check("rst_exec_ready", ready, 1);
    check("rst_exec_status", status, 0);
    check("rst_exec_write", write, 0);
    ref_status = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_exec_no_write", wr_count, wc);
    check("rst_exec_dest_kept", rf[6], ref_rf[6]);
    $display("reset during EXEC: writes=%0d R6=%h", wr_count - wc, rf[6]);

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 3'($urandom),
              16'($urandom), ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 8; i++) check("final_rf", rf[i], ref_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
